// File: rtl/mem_stage.sv
// MIPS pipeline memory-access stage: data-memory handshake, lane steering, load
// formatting, and the MEM/WB pipeline register.
module mem_stage #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        ex_valid,
    input  logic        ex_wreg,
    input  logic        ex_m2reg,
    input  logic        ex_rmem,
    input  logic        ex_wmem,
    input  logic [1:0]  ex_size,
    input  logic        ex_sign,
    input  logic [4:0]  ex_rn,
    input  logic [31:0] ex_alu,
    input  logic [31:0] ex_b,
    output logic        mem_stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        wb_valid,
    output logic        wb_wreg,
    output logic        wb_m2reg,
    output logic [4:0]  wb_rn,
    output logic [31:0] wb_alu,
    output logic [31:0] wb_mo,
    output logic        wb_aerr,
    output logic        wb_berr
);

    typedef enum logic {IDLE, REQ} state_t;

    state_t      r_state;
    logic [7:0]  r_cnt;
    logic        r_req, r_we;
    logic [31:0] r_addr, r_wdata;
    logic [3:0]  r_be;
    logic        r_wb_valid, r_wb_wreg, r_wb_m2reg, r_wb_aerr, r_wb_berr;
    logic [4:0]  r_wb_rn;
    logic [31:0] r_wb_alu, r_wb_mo;

    logic        w_memop, w_misalign, w_go, w_last, w_load;
    logic [3:0]  w_be;
    logic [31:0] w_wdata, w_fmt;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    logic        w_nxt_valid, w_nxt_wreg, w_nxt_aerr, w_nxt_berr;
    logic [31:0] w_nxt_mo;

    assign w_memop    = ex_valid & (ex_rmem | ex_wmem);
    assign w_misalign = ((ex_size == 2'b01) & ex_alu[0]) | (ex_size[1] & (|ex_alu[1:0]));
    assign w_go       = w_memop & ~w_misalign;
    assign w_last     = (r_cnt == 8'(TIMEOUT - 1));
    assign w_load     = ex_rmem & ~ex_wmem;

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = ex_b;
        unique case (ex_size)
            2'b00: begin
                w_be    = 4'b0001 << ex_alu[1:0];
                w_wdata = {4{ex_b[7:0]}};
            end
            2'b01: begin
                w_be    = 4'b0011 << {ex_alu[1], 1'b0};
                w_wdata = {2{ex_b[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        unique case (ex_alu[1:0])
            2'b00:   w_byte = dmem_rdata[7:0];
            2'b01:   w_byte = dmem_rdata[15:8];
            2'b10:   w_byte = dmem_rdata[23:16];
            default: w_byte = dmem_rdata[31:24];
        endcase
        w_half = ex_alu[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        unique case (ex_size)
            2'b00:   w_fmt = {{24{ex_sign & w_byte[7]}}, w_byte};
            2'b01:   w_fmt = {{16{ex_sign & w_half[15]}}, w_half};
            default: w_fmt = dmem_rdata;
        endcase
    end

    // Next MEM/WB contents; the register is rewritten on every edge, so
    // stall cycles must explicitly produce a bubble.
    always_comb begin
        mem_stall   = 1'b0;
        w_nxt_valid = 1'b0;
        w_nxt_wreg  = 1'b0;
        w_nxt_aerr  = 1'b0;
        w_nxt_berr  = 1'b0;
        w_nxt_mo    = '0;
        unique case (r_state)
            IDLE: begin
                mem_stall = w_go;
                if (!w_go) begin
                    w_nxt_valid = ex_valid;
                    w_nxt_aerr  = w_memop & w_misalign;
                    w_nxt_wreg  = ex_valid & ex_wreg & ~w_nxt_aerr;
                end
            end
            REQ: begin
                mem_stall = ~dmem_ack & ~w_last;
                if (dmem_ack) begin
                    w_nxt_valid = 1'b1;
                    w_nxt_wreg  = ex_wreg;
                    w_nxt_mo    = w_load ? w_fmt : '0;
                end else if (w_last) begin
                    w_nxt_valid = 1'b1;
                    w_nxt_berr  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_req      <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_be       <= '0;
            r_wdata    <= '0;
            r_wb_valid <= 1'b0;
            r_wb_wreg  <= 1'b0;
            r_wb_m2reg <= 1'b0;
            r_wb_rn    <= '0;
            r_wb_alu   <= '0;
            r_wb_mo    <= '0;
            r_wb_aerr  <= 1'b0;
            r_wb_berr  <= 1'b0;
        end else begin
            r_wb_valid <= w_nxt_valid;
            r_wb_wreg  <= w_nxt_wreg;
            r_wb_m2reg <= ex_m2reg;
            r_wb_rn    <= ex_rn;
            r_wb_alu   <= ex_alu;
            r_wb_mo    <= w_nxt_mo;
            r_wb_aerr  <= w_nxt_aerr;
            r_wb_berr  <= w_nxt_berr;
            unique case (r_state)
                IDLE: begin
                    if (w_go) begin
                        r_state <= REQ;
                        r_cnt   <= '0;
                        r_req   <= 1'b1;
                        r_we    <= ex_wmem;
                        r_addr  <= {ex_alu[31:2], 2'b00};
                        r_be    <= w_be;
                        r_wdata <= w_wdata;
                    end
                end
                REQ: begin
                    if (dmem_ack || w_last) begin
                        r_state <= IDLE;
                        r_req   <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign dmem_req   = r_req;
    assign dmem_we    = r_we;
    assign dmem_addr  = r_addr;
    assign dmem_be    = r_be;
    assign dmem_wdata = r_wdata;
    assign wb_valid   = r_wb_valid;
    assign wb_wreg    = r_wb_wreg;
    assign wb_m2reg   = r_wb_m2reg;
    assign wb_rn      = r_wb_rn;
    assign wb_alu     = r_wb_alu;
    assign wb_mo      = r_wb_mo;
    assign wb_aerr    = r_wb_aerr;
    assign wb_berr    = r_wb_berr;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized ops
// checked against an arithmetic model of lane steering and load formatting.
module tb_mem_stage;

    localparam int unsigned TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        clrn;
    logic        ex_valid, ex_wreg, ex_m2reg, ex_rmem, ex_wmem, ex_sign;
    logic [1:0]  ex_size;
    logic [4:0]  ex_rn;
    logic [31:0] ex_alu, ex_b;
    logic        mem_stall, dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic        wb_valid, wb_wreg, wb_m2reg, wb_aerr, wb_berr;
    logic [4:0]  wb_rn;
    logic [31:0] wb_alu, wb_mo;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    always #5 clk = ~clk;

    mem_stage #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .clrn(clrn),
        .ex_valid(ex_valid), .ex_wreg(ex_wreg), .ex_m2reg(ex_m2reg),
        .ex_rmem(ex_rmem), .ex_wmem(ex_wmem), .ex_size(ex_size), .ex_sign(ex_sign),
        .ex_rn(ex_rn), .ex_alu(ex_alu), .ex_b(ex_b),
        .mem_stall(mem_stall),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .wb_valid(wb_valid), .wb_wreg(wb_wreg), .wb_m2reg(wb_m2reg), .wb_rn(wb_rn),
        .wb_alu(wb_alu), .wb_mo(wb_mo), .wb_aerr(wb_aerr), .wb_berr(wb_berr)
    );

    function automatic logic [3:0] ref_be(input logic [1:0] sz, input logic [31:0] ad);
        if (sz == 2'd0) return 4'(1 << ad[1:0]);
        if (sz == 2'd1) return ad[1] ? 4'b1100 : 4'b0011;
        return 4'b1111;
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [1:0] sz, input logic [31:0] bd);
        if (sz == 2'd0) return bd[7:0] * 32'h0101_0101;
        if (sz == 2'd1) return bd[15:0] * 32'h0001_0001;
        return bd;
    endfunction

    function automatic logic [31:0] ref_fmt(input logic [1:0] sz, input logic sg,
                                            input logic [31:0] ad, input logic [31:0] rd);
        logic [31:0] x;
        if (sz == 2'd0) begin
            x = (rd >> (8 * ad[1:0])) & 32'hFF;
            if (sg && x[7]) x = x | 32'hFFFF_FF00;
        end else if (sz == 2'd1) begin
            x = (rd >> (16 * ad[1])) & 32'hFFFF;
            if (sg && x[15]) x = x | 32'hFFFF_0000;
        end else begin
            x = rd;
        end
        return x;
    endfunction

    // Issues one instruction, acking after dly REQ cycles (dly >= TIMEOUT never acks).
    task automatic run_op(input string nm, input logic v, input logic rm, input logic wm,
                          input logic [1:0] sz, input logic sg, input logic wr, input logic m2,
                          input logic [4:0] rn, input logic [31:0] ad, input logic [31:0] bd,
                          input int unsigned dly, input logic [31:0] rd);
        logic        memop, mis, load, done, exp_stall;
        logic [69:0] exp_req;
        logic [73:0] exp_wb;
        int unsigned k;
        memop = v && (rm || wm);
        mis   = memop && ((sz == 2'd1 && ad[0]) || (sz >= 2'd2 && (ad % 4) != 0));
        load  = rm && !wm;
        @(negedge clk);
        ex_valid = v; ex_rmem = rm; ex_wmem = wm; ex_size = sz; ex_sign = sg;
        ex_wreg = wr; ex_m2reg = m2; ex_rn = rn; ex_alu = ad; ex_b = bd;
        dmem_ack = 1'b0; dmem_rdata = $urandom;
        #1;
        if (!memop || mis) begin
            vectors++;
            if ({mem_stall, dmem_req} !== 2'b00) begin
                miscompares++;
                $display("FAIL %s idle_stall_req: got %b want 00", nm, {mem_stall, dmem_req});
            end
            @(posedge clk); #1;
            exp_wb = {v, v && wr && !mis, m2, rn, ad, 32'h0, mis, 1'b0};
        end else begin
            vectors++;
            if (mem_stall !== 1'b1) begin
                miscompares++;
                $display("FAIL %s issue_stall: got %b want 1", nm, mem_stall);
            end
            @(posedge clk); #1;
            exp_req = {1'b1, wm, ad & 32'hFFFF_FFFC, ref_be(sz, ad), ref_wdata(sz, bd)};
            k = 0;
            done = 1'b0;
            while (!done) begin
                vectors++;
                if ({dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata} !== exp_req) begin
                    miscompares++;
                    $display("FAIL %s req_bundle cyc%0d: got %h want %h", nm, k,
                             {dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata}, exp_req);
                end
                vectors++;
                if ({wb_valid, wb_wreg, wb_aerr, wb_berr} !== 4'b0000) begin
                    miscompares++;
                    $display("FAIL %s bubble cyc%0d: got %b want 0000", nm, k,
                             {wb_valid, wb_wreg, wb_aerr, wb_berr});
                end
                @(negedge clk);
                if (k == dly) begin
                    dmem_ack = 1'b1;
                    dmem_rdata = rd;
                end
                #1;
                exp_stall = !(k == dly || k == TIMEOUT - 1);
                vectors++;
                if (mem_stall !== exp_stall) begin
                    miscompares++;
                    $display("FAIL %s req_stall cyc%0d: got %b want %b", nm, k, mem_stall, exp_stall);
                end
                @(posedge clk); #1;
                if (k == dly || k == TIMEOUT - 1) done = 1'b1;
                k++;
            end
            vectors++;
            if (dmem_req !== 1'b0) begin
                miscompares++;
                $display("FAIL %s req_drop: got %b want 0", nm, dmem_req);
            end
            if (dly >= TIMEOUT)
                exp_wb = {1'b1, 1'b0, m2, rn, ad, 32'h0, 1'b0, 1'b1};
            else
                exp_wb = {1'b1, wr, m2, rn, ad, load ? ref_fmt(sz, sg, ad, rd) : 32'h0, 2'b00};
        end
        vectors++;
        if ({wb_valid, wb_wreg, wb_m2reg, wb_rn, wb_alu, wb_mo, wb_aerr, wb_berr} !== exp_wb) begin
            miscompares++;
            $display("FAIL %s wb: got %h want %h", nm,
                     {wb_valid, wb_wreg, wb_m2reg, wb_rn, wb_alu, wb_mo, wb_aerr, wb_berr}, exp_wb);
        end
    endtask

    task automatic test_reset();
        clrn = 1'b0;
        ex_valid = 1'b0; ex_rmem = 1'b0; ex_wmem = 1'b0; ex_size = 2'd0; ex_sign = 1'b0;
        ex_wreg = 1'b0; ex_m2reg = 1'b0; ex_rn = '0; ex_alu = '0; ex_b = '0;
        dmem_ack = 1'b0; dmem_rdata = '0;
        #12;
        clrn = 1'b1;
        // Start a word load and pull reset while it is outstanding.
        @(negedge clk);
        ex_valid = 1'b1; ex_rmem = 1'b1; ex_size = 2'd2; ex_wreg = 1'b1; ex_m2reg = 1'b1;
        ex_rn = 5'd9; ex_alu = 32'h0000_1000;
        @(posedge clk); #1;
        @(negedge clk); #1;
        vectors++;
        if (dmem_req !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_pre_req: got %b want 1", dmem_req);
        end
        #2 clrn = 1'b0;
        #1;
        vectors++;
        if ({dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata} !== 70'h0) begin
            miscompares++;
            $display("FAIL reset_dmem: got %h want 0", {dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata});
        end
        vectors++;
        if ({wb_valid, wb_wreg, wb_m2reg, wb_rn, wb_alu, wb_mo, wb_aerr, wb_berr} !== 74'h0) begin
            miscompares++;
            $display("FAIL reset_wb: got %h want 0",
                     {wb_valid, wb_wreg, wb_m2reg, wb_rn, wb_alu, wb_mo, wb_aerr, wb_berr});
        end
        @(negedge clk);
        ex_valid = 1'b0;
        clrn = 1'b1;
        run_op("alu_pass", 1, 0, 0, 2'd2, 0, 1, 0, 5'd5, 32'h1234_5678, 32'h0, 0, 32'h0);
    endtask

    task automatic test_load_byte();
        run_op("lb_signed", 1, 1, 0, 2'd0, 1, 1, 1, 5'd7, 32'h0000_0103, 32'h0, 3, 32'h80FF_0011);
        run_op("lbu", 1, 1, 0, 2'd0, 0, 1, 1, 5'd8, 32'h0000_0103, 32'h0, 0, 32'h80FF_0011);
        run_op("lh_signed", 1, 1, 0, 2'd1, 1, 1, 1, 5'd3, 32'h0000_0102, 32'h0, 1, 32'h8001_7FFF);
    endtask

    task automatic test_store_half();
        run_op("sh", 1, 0, 1, 2'd1, 0, 0, 0, 5'd0, 32'h0000_0202, 32'hAAAA_1234, 0, 32'h0);
        run_op("sb_rw_both", 1, 1, 1, 2'd0, 0, 0, 0, 5'd0, 32'h0000_0201, 32'h0000_00C3, 0, 32'hDEAD_BEEF);
    endtask

    task automatic test_misaligned();
        run_op("lw_mis", 1, 1, 0, 2'd2, 0, 1, 1, 5'd4, 32'h0000_0301, 32'h0, 0, 32'h0);
        run_op("sh_mis", 1, 0, 1, 2'd1, 0, 0, 0, 5'd0, 32'h0000_0303, 32'h5555, 0, 32'h0);
    endtask

    task automatic test_timeout();
        run_op("lw_timeout", 1, 1, 0, 2'd2, 0, 1, 1, 5'd6, 32'h0000_0400, 32'h0, TIMEOUT, 32'h0);
        // A stray ack while idle must not start or complete anything.
        @(negedge clk);
        ex_valid = 1'b1; ex_rmem = 1'b0; ex_wmem = 1'b0; ex_wreg = 1'b1; ex_m2reg = 1'b0;
        ex_rn = 5'd2; ex_alu = 32'hCAFE_0001;
        dmem_ack = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
        #1;
        vectors++;
        if ({mem_stall, dmem_req} !== 2'b00) begin
            miscompares++;
            $display("FAIL stray_ack_idle: got %b want 00", {mem_stall, dmem_req});
        end
        @(posedge clk); #1;
        vectors++;
        if ({wb_valid, wb_wreg, wb_rn, wb_alu, wb_mo, wb_berr} !== {1'b1, 1'b1, 5'd2, 32'hCAFE_0001, 32'h0, 1'b0}) begin
            miscompares++;
            $display("FAIL stray_ack_wb: got %h", {wb_valid, wb_wreg, wb_rn, wb_alu, wb_mo, wb_berr});
        end
    endtask

    task automatic test_back_to_back();
        run_op("b2b_lw", 1, 1, 0, 2'd2, 0, 1, 1, 5'd10, 32'h0000_0500, 32'h0, 1, 32'h0BAD_F00D);
        run_op("b2b_add", 1, 0, 0, 2'd2, 0, 1, 0, 5'd11, 32'h0000_0042, 32'h0, 0, 32'h0);
        run_op("b2b_sw", 1, 0, 1, 2'd2, 0, 0, 0, 5'd0, 32'h0000_0504, 32'h1357_9BDF, 0, 32'h0);
        run_op("b2b_nop", 0, 1, 0, 2'd2, 0, 0, 0, 5'd0, 32'h0000_0508, 32'h0, 0, 32'h0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            logic [1:0]  op;
            int unsigned dly;
            op  = 2'($urandom_range(0, 3));
            dly = ($urandom_range(0, 9) == 0) ? TIMEOUT : $urandom_range(0, 3);
            run_op("rand", ($urandom_range(0, 7) != 0), op[0], op[1], 2'($urandom), 1'($urandom),
                   1'($urandom), 1'($urandom), 5'($urandom), $urandom, $urandom, dly, $urandom);
        end
    endtask

    initial begin
        test_reset();
        test_load_byte();
        test_store_half();
        test_misaligned();
        test_timeout();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
